// File: rtl/neuron_event_dispatch.sv
// Event dispatcher: queues upstream spike events and feeds them to one of four
// neuron engines, draining the queue to the old engine before a mode switch.
module neuron_event_dispatch #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [1:0] mode_req,
    input  logic       mode_req_valid,
    output logic [3:0] eng_valid,
    output logic [7:0] eng_data,
    input  logic [3:0] eng_ready,
    input  logic [3:0] eng_idle,
    output logic [1:0] active_mode,
    output logic       switching,
    output logic [7:0] evt_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SWITCH
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [1:0]    active_mode_q, active_mode_d;
    logic [1:0]    pending_mode_q, pending_mode_d;
    logic [7:0]    evt_count_q, evt_count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic head_valid;
    logic push;
    logic pop;

    assign fifo_full  = (count_q == CNT_DEPTH);
    assign fifo_empty = (count_q == '0);
    assign head_valid = (state_q != ST_SWITCH) && !fifo_empty;

    assign in_ready    = (state_q == ST_RUN) && !fifo_full;
    assign push        = in_valid && in_ready;
    assign eng_valid   = head_valid ? (4'b0001 << active_mode_q) : 4'b0000;
    assign pop         = head_valid && eng_ready[active_mode_q];
    assign eng_data    = mem_q[rd_ptr_q];
    assign active_mode = active_mode_q;
    assign switching   = (state_q != ST_RUN);
    assign evt_count   = evt_count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        active_mode_d  = active_mode_q;
        pending_mode_d = pending_mode_q;
        evt_count_d    = evt_count_q;
        if (pop && (evt_count_q != 8'hFF)) begin
            evt_count_d = evt_count_q + 8'd1;
        end
        case (state_q)
            ST_RUN: begin
                if (mode_req_valid && (mode_req != active_mode_q)) begin
                    pending_mode_d = mode_req;
                    state_d        = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A request matching the current mode still completes the drain.
                if (mode_req_valid) begin
                    pending_mode_d = mode_req;
                end
                if (fifo_empty && eng_idle[active_mode_q]) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                active_mode_d = pending_mode_q;
                evt_count_d   = 8'd0;
                state_d       = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            active_mode_q  <= 2'd0;
            pending_mode_q <= 2'd0;
            evt_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            active_mode_q  <= active_mode_d;
            pending_mode_q <= pending_mode_d;
            evt_count_q    <= evt_count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_neuron_event_dispatch.sv
// Scoreboard bench for neuron_event_dispatch: accepted bytes are queued with the
// engine they must reach, and a monitor checks every delivery against the queue.
module tb_neuron_event_dispatch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [1:0] mode_req = 2'd0;
    logic       mode_req_valid = 1'b0;
    logic [3:0] eng_valid;
    logic [7:0] eng_data;
    logic [3:0] eng_ready = 4'b0000;
    logic [3:0] eng_idle = 4'b1111;
    logic [1:0] active_mode;
    logic       switching;
    logic [7:0] evt_count;

    typedef struct {
        logic [3:0] onehot;
        logic [7:0] data;
    } exp_t;

    exp_t sbQ[$];
    int   assertCnt = 0;
    int   failCnt = 0;
    int   deliveredCnt = 0;
    logic [1:0] expMode = 2'd0;

    neuron_event_dispatch #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .eng_valid      (eng_valid),
        .eng_data       (eng_data),
        .eng_ready      (eng_ready),
        .eng_idle       (eng_idle),
        .active_mode    (active_mode),
        .switching      (switching),
        .evt_count      (evt_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte and holds it until accepted, bounded by a cycle budget.
    task automatic applyStimulus(input logic [7:0] b);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) checkOutput("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic strobeMode(input logic [1:0] m);
        mode_req       = m;
        mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
    endtask

    // Monitor: deliveries are checked before this edge's push is recorded.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((eng_valid & eng_ready) != 4'b0000) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_delivery", 32'(eng_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("deliver_valid", 32'(eng_valid), 32'(e.onehot));
                    checkOutput("deliver_data", 32'(eng_data), 32'(e.data));
                    deliveredCnt++;
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.onehot = 4'b0001 << expMode;
                n.data   = in_data;
                sbQ.push_back(n);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        checkOutput("rst_eng_valid", 32'(eng_valid), 32'h0);
        checkOutput("rst_switching", 32'(switching), 32'h0);
        checkOutput("rst_active_mode", 32'(active_mode), 32'h0);
        checkOutput("rst_evt_count", 32'(evt_count), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'h1);

        // In-order delivery to LIF
        eng_ready = 4'b0001;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        repeat (3) step();
        checkOutput("t1_evt_count", 32'(evt_count), 32'd3);
        checkOutput("t1_delivered", 32'(deliveredCnt), 32'd3);

        // Full FIFO backpressure, fifth byte held upstream
        eng_ready = 4'b0000;
        applyStimulus(8'hA1);
        applyStimulus(8'hA2);
        applyStimulus(8'hA3);
        applyStimulus(8'hA4);
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        checkOutput("t2_full_in_ready", 32'(in_ready), 32'h0);
        step();
        step();
        checkOutput("t2_hold_in_ready", 32'(in_ready), 32'h0);
        checkOutput("t2_head_data", 32'(eng_data), 32'hA1);
        checkOutput("t2_head_valid", 32'(eng_valid), 32'h1);
        eng_ready = 4'b0001;
        step();
        eng_ready = 4'b0000;
        #1;
        checkOutput("t2_after_pop_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        #1;
        checkOutput("t2_refull_in_ready", 32'(in_ready), 32'h0);
        eng_ready = 4'b0001;
        repeat (6) step();
        checkOutput("t2_evt_count", 32'(evt_count), 32'd8);

        // Drain to LIF, wait for idle, switch to FST
        eng_ready = 4'b0000;
        eng_idle  = 4'b0000;
        applyStimulus(8'h61);
        applyStimulus(8'h62);
        strobeMode(2'd2);
        #1;
        checkOutput("t3_switching", 32'(switching), 32'h1);
        checkOutput("t3_in_ready", 32'(in_ready), 32'h0);
        eng_ready = 4'b0001;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t3_wait_switching", 32'(switching), 32'h1);
            checkOutput("t3_wait_mode", 32'(active_mode), 32'h0);
        end
        checkOutput("t3_evt_count_pre", 32'(evt_count), 32'd10);
        eng_idle = 4'b0001;
        step();
        mode_req       = 2'd1;
        mode_req_valid = 1'b1;
        #1;
        checkOutput("t3_sw_switching", 32'(switching), 32'h1);
        checkOutput("t3_sw_eng_valid", 32'(eng_valid), 32'h0);
        step();
        mode_req_valid = 1'b0;
        #1;
        checkOutput("t3_new_mode", 32'(active_mode), 32'h2);
        checkOutput("t3_run_switching", 32'(switching), 32'h0);
        checkOutput("t3_evt_cleared", 32'(evt_count), 32'h0);
        expMode = 2'd2;

        // Last request in DRAIN wins; non-active ready bits ignored
        eng_ready = 4'b0000;
        eng_idle  = 4'b0000;
        applyStimulus(8'h71);
        mode_req       = 2'd1;
        mode_req_valid = 1'b1;
        step();
        mode_req = 2'd3;
        step();
        mode_req_valid = 1'b0;
        eng_ready = 4'b1011;
        #1;
        checkOutput("t4_valid", 32'(eng_valid), 32'h4);
        checkOutput("t4_data", 32'(eng_data), 32'h71);
        step();
        checkOutput("t4_no_pop_valid", 32'(eng_valid), 32'h4);
        checkOutput("t4_switching", 32'(switching), 32'h1);
        eng_ready = 4'b0100;
        eng_idle  = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!switching) break;
        end
        checkOutput("t4_done_switching", 32'(switching), 32'h0);
        checkOutput("t4_final_mode", 32'(active_mode), 32'h3);
        expMode = 2'd3;

        // Request for the current mode is ignored
        strobeMode(2'd3);
        #1;
        checkOutput("t5_switching", 32'(switching), 32'h0);
        checkOutput("t5_mode", 32'(active_mode), 32'h3);
        step();
        checkOutput("t5_switching_later", 32'(switching), 32'h0);

        // Reset mid-DRAIN discards queue and pending mode
        eng_ready = 4'b0000;
        eng_idle  = 4'b0000;
        applyStimulus(8'h81);
        applyStimulus(8'h82);
        applyStimulus(8'h83);
        strobeMode(2'd0);
        #1;
        checkOutput("t6_switching", 32'(switching), 32'h1);
        checkOutput("t6_valid", 32'(eng_valid), 32'h8);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(eng_valid), 32'h0);
        checkOutput("t6_rst_mode", 32'(active_mode), 32'h0);
        checkOutput("t6_rst_switching", 32'(switching), 32'h0);
        sbQ.delete();
        expMode = 2'd0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        checkOutput("t6_in_ready", 32'(in_ready), 32'h1);
        checkOutput("t6_empty_valid", 32'(eng_valid), 32'h0);
        eng_ready = 4'b0001;
        eng_idle  = 4'b1111;
        repeat (3) step();
        checkOutput("t6_still_empty", 32'(eng_valid), 32'h0);
        checkOutput("t6_evt_count", 32'(evt_count), 32'h0);

        checkOutput("total_delivered", 32'(deliveredCnt), 32'd11);
        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/neuron_event_dispatch.md
NEURON_EVENT_DISPATCH -- requirements
Module: neuron_event_dispatch

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), setting the input event queue depth.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1, meaning an upstream spike event is offered.
REQ-005 The module SHALL have port in_data, input, 8, the upstream event byte.
REQ-006 The module SHALL have port in_ready, output, 1, meaning an event is accepted this cycle when in_valid=1.
REQ-007 The module SHALL have port mode_req, input, 2, the requested engine: LIF=0, TD=1, FST=2, CONV=3.
REQ-008 The module SHALL have port mode_req_valid, input, 1, a single-cycle strobe qualifying mode_req.
REQ-009 The module SHALL have port eng_valid, output, 4, a one-hot event valid per engine (bit index = mode code).
REQ-010 The module SHALL have port eng_data, output, 8, the event byte shared by all engines.
REQ-011 The module SHALL have port eng_ready, input, 4, the per-engine accept signal.
REQ-012 The module SHALL have port eng_idle, input, 4, meaning the engine has no event in flight.
REQ-013 The module SHALL have port active_mode, output, 2, the engine currently receiving events.
REQ-014 The module SHALL have port switching, output, 1, high while in the DRAIN or SWITCH state.
REQ-015 The module SHALL have port evt_count, output, 8, the number of events delivered since the last mode switch.

Function
REQ-016 The module SHALL implement states RUN, DRAIN and SWITCH.
REQ-017 in_ready SHALL be 1 only in RUN with the FIFO not full; there is no same-cycle bypass when the FIFO is full.
REQ-018 A push SHALL occur on in_valid && in_ready, and the byte SHALL be visible on eng_data no earlier than the next cycle.
REQ-019 eng_data SHALL equal the FIFO head, and eng_valid[active_mode] SHALL equal FIFO-not-empty in RUN and DRAIN; all other eng_valid bits SHALL be 0, and all bits SHALL be 0 in SWITCH.
REQ-020 A pop SHALL occur on eng_valid[active_mode] && eng_ready[active_mode].
REQ-021 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL never exceed FIFO_DEPTH or underflow.
REQ-023 evt_count SHALL increment by 1 per pop, saturate at 255, and clear to 0 on the SWITCH->RUN transition.
REQ-024 In RUN, a mode_req_valid with mode_req != active_mode SHALL latch pending_mode and move to DRAIN.
REQ-025 A mode_req_valid with mode_req == active_mode in RUN SHALL be ignored.
REQ-026 In DRAIN, in_ready SHALL be 0 and the FIFO SHALL continue to drain to the old engine.
REQ-027 In DRAIN, a further mode_req_valid SHALL overwrite pending_mode (last wins); a request equal to active_mode SHALL still complete the drain and switch with no net mode change.
REQ-028 DRAIN->SWITCH SHALL occur when the FIFO is empty and eng_idle[active_mode]=1, evaluated in the same cycle.
REQ-029 SWITCH SHALL last exactly one cycle: active_mode <= pending_mode, then the state returns to RUN.
REQ-030 A mode_req_valid arriving in SWITCH SHALL be ignored.
REQ-031 eng_ready and eng_idle bits of non-active engines SHALL have no effect.

Reset
REQ-032 While rst_n=0, and immediately on its assertion regardless of state, the module SHALL set: state RUN, FIFO empty, pointers 0, active_mode=0 (LIF), pending_mode=0, evt_count=0, eng_valid=0, switching=0.
REQ-033 Reset asserted mid-DRAIN SHALL discard queued events and pending_mode.
REQ-034 After rst_n deasserts, in_ready SHALL be 1 on the first clock edge.

Verification
REQ-035 The bench SHALL cover: reset, then push 0x11,0x22,0x33 with eng_ready=4'b0001 -> eng_valid=4'b0001, bytes delivered in order, evt_count=3.
REQ-036 The bench SHALL cover: eng_ready=0 and FIFO_DEPTH+1 pushes offered -> in_ready=0 after 4 accepts, the 5th byte held upstream and accepted after one pop.
REQ-037 The bench SHALL cover: 2 events queued, mode_req=2 strobed, eng_idle[0] held 0 for 3 cycles after empty -> switching=1, in_ready=0, both events go to LIF, active_mode=2 one cycle after idle rises, evt_count=0.
REQ-038 The bench SHALL cover: in DRAIN, strobes mode_req=1 then mode_req=3 -> final active_mode=3.
REQ-039 The bench SHALL cover: mode_req==active_mode in RUN -> no state change and switching stays 0.
REQ-040 The bench SHALL cover: rst_n pulsed low mid-DRAIN with 3 events queued -> active_mode=0, eng_valid=0, FIFO empty, in_ready=1 after release.
